// File: rtl/spi_wb_responder.sv
// Wishbone-programmable SPI master: CTRL/DIVIDER/SS/DATA registers, transfers of up to
// 32 bits on sclk/mosi/miso with an optional completion interrupt.
module spi_wb_responder #(
   parameter int unsigned SS_NB   = 8,
   parameter logic [15:0] DIV_RST = 16'hFFFF
) (
   input  logic             CLK_48,
   input  logic             rst,
   input  logic [4:0]       wb_adr,
   input  logic [31:0]      wb_di,
   output logic [31:0]      wb_do,
   input  logic [3:0]       wb_sel,
   input  logic             wb_we,
   input  logic             wb_stb,
   input  logic             wb_cyc,
   output logic             wb_ack,
   output logic             wb_err,
   output logic             wb_int,
   output logic             sclk,
   output logic             mosi,
   input  logic             miso,
   output logic [SS_NB-1:0] ss_n
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StXfer = 1'b1;

   localparam logic [4:0] AdrData = 5'h00;
   localparam logic [4:0] AdrCtrl = 5'h10;
   localparam logic [4:0] AdrDiv  = 5'h14;
   localparam logic [4:0] AdrSs   = 5'h18;

   // Index into flags_q, which holds CTRL[13:9].
   localparam int unsigned FlAss   = 4;
   localparam int unsigned FlIe    = 3;
   localparam int unsigned FlLsb   = 2;
   localparam int unsigned FlTxNeg = 1;
   localparam int unsigned FlRxNeg = 0;

   logic [0:0]       state_q, state_d;
   logic [4:0]       flags_q, flags_d;
   logic [6:0]       char_len_q, char_len_d;
   logic [15:0]      div_q, div_d;
   logic [SS_NB-1:0] ss_q, ss_d;
   logic [31:0]      tx_q, tx_d;
   logic [31:0]      rx_q, rx_d;
   logic [31:0]      sh_q, sh_d;
   logic [31:0]      rxs_q, rxs_d;
   logic [15:0]      hp_q, hp_d;
   logic [6:0]       cnt_q, cnt_d;
   logic [5:0]       n_q, n_d;
   logic             sclk_q, sclk_d;
   logic             int_q, int_d;
   logic             ack_q, err_q;
   logic [31:0]      do_q, do_d;
   logic [SS_NB-1:0] ss_n_q, ss_n_d;

   logic        acc, hit, wr, busy;
   logic        sel_data, sel_ctrl, sel_div, sel_ss;
   logic        go, done, rising, advance, sample;
   logic [5:0]  n_go;
   logic [31:0] rxs_next, rxs_upd;

   function automatic logic [5:0] eff_len(input logic [6:0] cl);
      return (cl == 7'd0 || cl > 7'd32) ? 6'd32 : cl[5:0];
   endfunction

   function automatic logic [31:0] len_mask(input logic [5:0] n);
      return (n >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
   endfunction

   assign sel_data = (wb_adr == AdrData);
   assign sel_ctrl = (wb_adr == AdrCtrl);
   assign sel_div  = (wb_adr == AdrDiv);
   assign sel_ss   = (wb_adr == AdrSs);
   assign hit      = sel_data | sel_ctrl | sel_div | sel_ss;
   // One access per strobe: the cycle carrying ack/err does not start another.
   assign acc      = wb_stb & wb_cyc & ~ack_q & ~err_q;
   assign wr       = acc & hit & wb_we;
   assign busy     = (state_q == StXfer);

   always_comb begin
      state_d    = state_q;
      flags_d    = flags_q;
      char_len_d = char_len_q;
      div_d      = div_q;
      ss_d       = ss_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      sh_d       = sh_q;
      rxs_d      = rxs_q;
      hp_d       = hp_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      sclk_d     = sclk_q;
      int_d      = int_q;
      go         = 1'b0;
      done       = 1'b0;
      rising     = 1'b0;
      advance    = 1'b0;
      sample     = 1'b0;
      rxs_next   = rxs_q;
      rxs_upd    = rxs_q;

      if (wr && sel_ss && wb_sel[0]) begin
         ss_d = wb_di[SS_NB-1:0];
      end
      if (wr && !busy) begin
         if (sel_ctrl) begin
            if (wb_sel[0]) char_len_d = wb_di[6:0];
            if (wb_sel[1]) begin
               flags_d = wb_di[13:9];
               go      = wb_di[8];
            end
         end
         if (sel_div) begin
            if (wb_sel[0]) div_d[7:0]  = wb_di[7:0];
            if (wb_sel[1]) div_d[15:8] = wb_di[15:8];
         end
         if (sel_data) begin
            for (int k = 0; k < 4; k++) begin
               if (wb_sel[k]) tx_d[8*k +: 8] = wb_di[8*k +: 8];
            end
         end
      end

      n_go = eff_len(char_len_d);

      if (go) begin
         state_d = StXfer;
         n_d     = n_go;
         cnt_d   = {n_go, 1'b0};
         hp_d    = div_q;
         sclk_d  = 1'b0;
         rxs_d   = '0;
         // MSB-first keeps the next bit at [31], LSB-first at [0].
         sh_d    = flags_d[FlLsb] ? tx_q : (tx_q << (6'd32 - n_go));
      end else if (busy) begin
         rising   = ~sclk_q;
         // With TX on the rising toggle, skip the first one so bit 0 is not lost.
         advance  = flags_q[FlTxNeg] ? ~rising : (rising && (cnt_q != {n_q, 1'b0}));
         sample   = flags_q[FlRxNeg] ? ~rising : rising;
         rxs_next = flags_q[FlLsb] ? ((rxs_q >> 1) | ({31'b0, miso} << (n_q - 6'd1)))
                                   : {rxs_q[30:0], miso};
         if (hp_q == 16'd0) begin
            hp_d    = div_q;
            sclk_d  = ~sclk_q;
            cnt_d   = cnt_q - 7'd1;
            rxs_upd = sample ? rxs_next : rxs_q;
            rxs_d   = rxs_upd;
            if (advance) sh_d = flags_q[FlLsb] ? (sh_q >> 1) : (sh_q << 1);
            if (cnt_q == 7'd1) begin
               done    = 1'b1;
               state_d = StIdle;
               rx_d    = rxs_upd & len_mask(n_q);
            end
         end else begin
            hp_d = hp_q - 16'd1;
         end
      end

      if (acc) int_d = 1'b0;
      if (done && flags_q[FlIe]) int_d = 1'b1;
   end

   always_comb begin
      ss_n_d = ~(ss_d & {SS_NB{~flags_d[FlAss] | (state_d == StXfer)}});
   end

   always_comb begin
      do_d = '0;
      if (acc && !wb_we) begin
         case (wb_adr)
            AdrData: do_d = rx_q;
            AdrCtrl: do_d = {18'b0, flags_q, busy, 1'b0, char_len_q};
            AdrDiv:  do_d = {16'b0, div_q};
            AdrSs:   do_d = {{(32-SS_NB){1'b0}}, ss_q};
            default: do_d = '0;
         endcase
      end
   end

   always_ff @(posedge CLK_48) begin
      if (rst) begin
         state_q    <= StIdle;
         flags_q    <= '0;
         char_len_q <= '0;
         div_q      <= DIV_RST;
         ss_q       <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         sh_q       <= '0;
         rxs_q      <= '0;
         hp_q       <= '0;
         cnt_q      <= '0;
         n_q        <= '0;
         sclk_q     <= 1'b0;
         int_q      <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         do_q       <= '0;
         ss_n_q     <= '1;
      end else begin
         state_q    <= state_d;
         flags_q    <= flags_d;
         char_len_q <= char_len_d;
         div_q      <= div_d;
         ss_q       <= ss_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         sh_q       <= sh_d;
         rxs_q      <= rxs_d;
         hp_q       <= hp_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         sclk_q     <= sclk_d;
         int_q      <= int_d;
         ack_q      <= acc & hit;
         err_q      <= acc & ~hit;
         do_q       <= do_d;
         ss_n_q     <= ss_n_d;
      end
   end

   assign wb_ack = ack_q;
   assign wb_err = err_q;
   assign wb_do  = do_q;
   assign wb_int = int_q;
   assign sclk   = sclk_q;
   assign ss_n   = ss_n_q;
   assign mosi   = busy & (flags_q[FlLsb] ? sh_q[0] : sh_q[31]);

endmodule
